// File: rtl/calc_pkg.sv
// Shared definitions for the calculator responder: op-select encoding and
// the control FSM state type.
package calc_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10,
        ST_DONE = 2'b11
    } state_t;

endpackage

// File: rtl/calc_iter_datapath.sv
// Iterative multiply (shift-add) and restoring divide datapath; one step per
// cycle for exactly WIDTH cycles after start. Requires WIDTH >= 2.
module calc_iter_datapath
    import calc_pkg::*;
#(
    parameter int WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [1:0]           op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic                 busy_r;
    logic [1:0]           op_r;
    logic [CW-1:0]        cnt_r;
    logic [2*WIDTH-1:0]   acc_r;
    logic [2*WIDTH-1:0]   mcand_r;
    logic [WIDTH-1:0]     mplier_r;
    logic [WIDTH-1:0]     rem_r;
    logic [WIDTH-1:0]     quo_r;
    logic [WIDTH-1:0]     dvsr_r;

    logic [2*WIDTH-1:0]   acc_n_s;
    logic [WIDTH:0]       rem_sh_s;
    logic [WIDTH:0]       diff_s;
    logic [WIDTH-1:0]     rem_n_s;
    logic [WIDTH-1:0]     quo_n_s;

    // One multiply step and one restoring-divide step, both from current state
    always_comb begin
        acc_n_s  = acc_r;
        rem_sh_s = {rem_r, quo_r[WIDTH-1]};
        diff_s   = rem_sh_s - {1'b0, dvsr_r};
        rem_n_s  = rem_r;
        quo_n_s  = quo_r;
        if (mplier_r[0]) begin
            acc_n_s = acc_r + mcand_r;
        end else begin
            acc_n_s = acc_r;
        end
        // No borrow means the shifted remainder covers the divisor: keep the difference
        if (!diff_s[WIDTH]) begin
            rem_n_s = diff_s[WIDTH-1:0];
            quo_n_s = {quo_r[WIDTH-2:0], 1'b1};
        end else begin
            rem_n_s = rem_sh_s[WIDTH-1:0];
            quo_n_s = {quo_r[WIDTH-2:0], 1'b0};
        end
    end

    // Result is the post-step value so the top can capture it on the last edge
    always_comb begin
        done = busy_r && (cnt_r == CNT_LAST);
        if (op_r == OP_MUL) begin
            result = acc_n_s;
        end else begin
            result = {rem_n_s, quo_n_s};
        end
    end

    // Operand load on start, then one iteration per cycle while busy
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r   <= 1'b0;
            op_r     <= OP_ADD;
            cnt_r    <= CNT_ZERO;
            acc_r    <= {(2*WIDTH){1'b0}};
            mcand_r  <= {(2*WIDTH){1'b0}};
            mplier_r <= {WIDTH{1'b0}};
            rem_r    <= {WIDTH{1'b0}};
            quo_r    <= {WIDTH{1'b0}};
            dvsr_r   <= {WIDTH{1'b0}};
        end else if (start) begin
            busy_r   <= 1'b1;
            op_r     <= op;
            cnt_r    <= CNT_ZERO;
            acc_r    <= {(2*WIDTH){1'b0}};
            mcand_r  <= {{WIDTH{1'b0}}, a};
            mplier_r <= b;
            rem_r    <= {WIDTH{1'b0}};
            quo_r    <= a;
            dvsr_r   <= b;
        end else if (busy_r) begin
            acc_r    <= acc_n_s;
            mcand_r  <= mcand_r << 1;
            mplier_r <= mplier_r >> 1;
            rem_r    <= rem_n_s;
            quo_r    <= quo_n_s;
            if (done) begin
                busy_r <= 1'b0;
                cnt_r  <= CNT_ZERO;
            end else begin
                cnt_r  <= cnt_r + CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/calc_responder.sv
// Handshaked calculator responder: accepts one op per transaction, computes
// add/sub directly and mul/div through the iterative datapath, holds result.
module calc_responder
    import calc_pkg::*;
#(
    parameter int WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 s1,
    input  logic                 s0,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   y,
    output logic                 yrep
);

    state_t               state_r;
    logic                 in_ready_r;
    logic                 out_valid_r;
    logic [2*WIDTH-1:0]   y_r;
    logic                 yrep_r;

    logic [1:0]           op_s;
    logic                 b_zero_s;
    logic                 start_s;
    logic                 iter_done_s;
    logic [2*WIDTH-1:0]   iter_result_s;
    logic [2*WIDTH-1:0]   quick_y_s;
    logic                 quick_rep_s;

    assign op_s     = {s1, s0};
    assign b_zero_s = (b == {WIDTH{1'b0}});

    // Only mul and non-zero div need the iterative engine
    always_comb begin
        start_s = 1'b0;
        if ((state_r == ST_IDLE) && in_valid) begin
            start_s = (op_s == OP_MUL) || ((op_s == OP_DIV) && !b_zero_s);
        end else begin
            start_s = 1'b0;
        end
    end

    // Single-cycle results: add, sub (magnitude plus borrow) and divide-by-zero
    always_comb begin
        quick_y_s   = {(2*WIDTH){1'b0}};
        quick_rep_s = 1'b0;
        case (op_s)
            OP_ADD: begin
                quick_y_s   = {{WIDTH{1'b0}}, a} + {{WIDTH{1'b0}}, b};
                quick_rep_s = 1'b0;
            end
            OP_SUB: begin
                if (a < b) begin
                    quick_y_s   = {{WIDTH{1'b0}}, b - a};
                    quick_rep_s = 1'b1;
                end else begin
                    quick_y_s   = {{WIDTH{1'b0}}, a - b};
                    quick_rep_s = 1'b0;
                end
            end
            OP_DIV: begin
                quick_y_s   = {(2*WIDTH){1'b0}};
                quick_rep_s = 1'b1;
            end
            default: begin
                quick_y_s   = {(2*WIDTH){1'b0}};
                quick_rep_s = 1'b0;
            end
        endcase
    end

    calc_iter_datapath #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk    (clk),
        .rst    (rst),
        .start  (start_s),
        .op     (op_s),
        .a      (a),
        .b      (b),
        .done   (iter_done_s),
        .result (iter_result_s)
    );

    // Control FSM with registered handshake and result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            y_r         <= {(2*WIDTH){1'b0}};
            yrep_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        in_ready_r <= 1'b0;
                        if (start_s) begin
                            state_r <= (op_s == OP_MUL) ? ST_MUL : ST_DIV;
                        end else begin
                            state_r     <= ST_DONE;
                            out_valid_r <= 1'b1;
                            y_r         <= quick_y_s;
                            yrep_r      <= quick_rep_s;
                        end
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (iter_done_s) begin
                        state_r     <= ST_DONE;
                        out_valid_r <= 1'b1;
                        y_r         <= iter_result_s;
                        yrep_r      <= 1'b0;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_r     <= ST_IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign y         = y_r;
    assign yrep      = yrep_r;

endmodule

// File: tb/tb_calc_responder.sv
// Self-checking bench for calc_responder: directed scenarios plus randomized
// transactions against an arithmetic reference model.
module tb_calc_responder;

    localparam int W = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic             s1;
    logic             s0;
    logic             out_valid;
    logic             out_ready;
    logic [2*W-1:0]   y;
    logic             yrep;

    int n_checks = 0;
    int n_fail   = 0;
    int prev_y   = 0;

    calc_responder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .s1        (s1),
        .s0        (s0),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .yrep      (yrep)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: plain arithmetic on integers, plus expected accept-to-valid latency
    task automatic ref_calc(input int ai, input int bi, input int op,
                            output int ye, output int re, output int lat);
        ye = 0; re = 0; lat = 1;
        case (op)
            0: ye = ai + bi;
            1: begin re = (ai < bi) ? 1 : 0; ye = (ai < bi) ? bi - ai : ai - bi; end
            2: begin ye = ai * bi; lat = 1 + W; end
            default: begin
                if (bi == 0) begin ye = 0; re = 1; end
                else begin ye = (ai % bi) * (1 << W) + ai / bi; lat = 1 + W; end
            end
        endcase
    endtask

    task automatic wait_ready();
        int k = 0;
        while (!in_ready && k < 50) begin
            @(posedge clk); #1; k++;
        end
        if (!in_ready) check_val("in_ready_timeout", 32'(in_ready), 32'd1);
    endtask

    task automatic run_op(input int ai, input int bi, input int op,
                          input int stall, input bit pend, input bit early_ready);
        int ye, re, elat, lat;
        logic [1:0] opv;
        ref_calc(ai, bi, op, ye, re, elat);
        opv = op[1:0];
        wait_ready();
        a = ai[W-1:0]; b = bi[W-1:0]; {s1, s0} = opv;
        in_valid = 1'b1; out_ready = early_ready;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); {s1, s0} = 2'($urandom);
        lat = 1;
        while (!out_valid && lat < 20) begin
            check_val("busy_in_ready", 32'(in_ready), 32'd0);
            check_val("busy_y_held", 32'(y), 32'(prev_y));
            @(posedge clk); #1; lat++;
        end
        check_val("latency", 32'(lat), 32'(elat));
        check_val("y", 32'(y), 32'(ye));
        check_val("yrep", 32'(yrep), 32'(re));
        check_val("done_in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < stall; i++) begin
            if (pend) begin
                in_valid = 1'b1; a = W'($urandom); b = W'($urandom); {s1, s0} = 2'($urandom);
            end
            @(posedge clk); #1;
            check_val("stall_valid", 32'(out_valid), 32'd1);
            check_val("stall_in_ready", 32'(in_ready), 32'd0);
            check_val("stall_y", 32'(y), 32'(ye));
            check_val("stall_yrep", 32'(yrep), 32'(re));
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_val("post_valid", 32'(out_valid), 32'd0);
        check_val("post_in_ready", 32'(in_ready), 32'd1);
        check_val("post_y_held", 32'(y), 32'(ye));
        prev_y = ye;
    endtask

    initial begin
        int ai, bi, op, st;
        bit pd, er;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; s1 = 1'b0; s0 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_val("rst_in_ready", 32'(in_ready), 32'd1);
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_val("rst_y", 32'(y), 32'd0);
        check_val("rst_yrep", 32'(yrep), 32'd0);

        run_op(2, 1, 0, 0, 1'b0, 1'b1);
        run_op(3, 3, 0, 0, 1'b0, 1'b1);
        run_op(2, 1, 1, 0, 1'b0, 1'b1);
        run_op(0, 3, 1, 0, 1'b0, 1'b1);
        run_op(3, 3, 2, 0, 1'b0, 1'b1);
        run_op(3, 2, 3, 0, 1'b0, 1'b1);
        run_op(2, 0, 3, 0, 1'b0, 1'b1);
        run_op(3, 2, 2, 5, 1'b1, 1'b0);
        run_op(1, 2, 0, 0, 1'b0, 1'b0);

        // Reset in the middle of a multiply discards it
        wait_ready();
        a = 2'd3; b = 2'd3; {s1, s0} = 2'b10; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_val("midrst_valid", 32'(out_valid), 32'd0);
        check_val("midrst_in_ready", 32'(in_ready), 32'd1);
        check_val("midrst_y", 32'(y), 32'd0);
        check_val("midrst_yrep", 32'(yrep), 32'd0);
        prev_y = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check_val("midrst_no_resp", 32'(out_valid), 32'd0);
        end
        out_ready = 1'b0;
        run_op(1, 1, 0, 0, 1'b0, 1'b1);

        for (int n = 0; n < 40; n++) begin
            op = $urandom_range(0, 3);
            ai = $urandom_range(0, 3);
            bi = $urandom_range(0, 3);
            st = $urandom_range(0, 3);
            pd = 1'($urandom);
            er = (st == 0) ? 1'($urandom) : 1'b0;
            run_op(ai, bi, op, st, pd, er);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
